comp_seq_ctrl: RTL and testbench
================================

# comp_seq_ctrl

Sequential magnitude-compare controller for the ALU comparator path. It time-multiplexes a single `comp_2` slice across a WIDTH-bit operand pair, two bits per cycle, from the MSB pair downward. The EQ/GT cascade is carried in internal registers between cycles, and the sequence terminates early once the result is decided. It supports signed and unsigned comparison and uses a start/ready handshake toward the ALU control.

## Interface

- `WIDTH`, default 32: operand width; must be even and ≥ 2; slice count N = WIDTH/2.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request a comparison; sampled only in IDLE or DONE.
- `is_signed`  in  1  1 = two's-complement compare, 0 = unsigned; sampled with `start`.
- `data_A`  in  WIDTH  operand A; sampled with `start`.
- `data_B`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high in RUN.
- `ready`  out  1  one-cycle pulse in DONE; results valid from this cycle on.
- `isEqual`  out  1  A == B.
- `isGreaterThan`  out  1  A > B.
- `isLessThan`  out  1  A < B.

## Operation

- Instantiates exactly one `comp_2`.
  - Slice inputs: A/B = latched operand bits [2k+1:2k] at current index k.
  - Cascade inputs: EQ1 = `eq_r`, GT1 = `gt_r`.
- Signed mode: bit WIDTH-1 of both latched operands is inverted at latch time. The unsigned slice chain then yields the signed order. No other signed handling.
- States:
  - IDLE: `busy`=0, `ready`=0; outputs hold last result.
  - `start`=1 in IDLE: latch operands (with sign fix); `eq_r`←1, `gt_r`←0, k←N-1; → RUN.
  - RUN, each edge:
    - `eq_r`←EQ0, `gt_r`←GT0.
    - If k==0 or EQ0==0 → DONE, and the result registers load from EQ0/GT0.
    - Else k←k-1.
  - DONE, one cycle: `ready`=1.
    - `start`=1 here is accepted exactly as from IDLE (back-to-back ops).
    - Otherwise → IDLE.
- Result registers:
  - `isEqual`←EQ0, `isGreaterThan`←GT0, `isLessThan`←~EQ0 & ~GT0.
  - Exactly one of the three is high after any completed op.
  - They change only on the edge entering DONE, hold through IDLE and the following RUN, and update only at the next DONE.
- `start` during RUN is ignored; operand inputs may change freely after the start edge.
- Early-exit correctness: once EQ0 = 0 the cascade is fixed (GT1 dominates when EQ1 = 0), so the remaining pairs are skipped.

## Timing

- Reset (any state, including mid-RUN): next state IDLE.
  - `busy`, `ready`, `isEqual`, `isGreaterThan`, `isLessThan` all 0; k = 0, `eq_r` = 0, `gt_r` = 0.
  - The in-flight operation is discarded and never reports `ready`.
- Start at edge E0 → RUN from E0.
- Let j = index of the first differing 2-bit pair counted from the MSB pair (j = 1 for the MSB pair), or j = N if A == B.
  - DONE is entered at edge Ej.
  - `ready` is high for the cycle between Ej and Ej+1.
  - `busy` is high for j cycles.
- Best case 1 cycle, worst case N cycles (16 for WIDTH=32).
- Back-to-back: `start` in the DONE cycle → RUN at Ej+1, with no IDLE cycle between ops.
- No combinational path from inputs to outputs.

## Test plan

- Reset → all outputs 0 the cycle after reset; `start`=1 held during reset is ignored.
- WIDTH=32, unsigned, A=0x80000000, B=0x7FFFFFFF → `isGreaterThan`=1, `busy` for 1 cycle, `ready` at E1.
- Same operands, `is_signed`=1 → `isLessThan`=1, `ready` at E1.
- A=B=0x12345678 → `isEqual`=1, `busy` 16 cycles, `ready` at E16. Then A=0x00000001, B=0x00000002 → `isLessThan`=1, `ready` at E16.
- A=0x00000004, B=0x00000000 → `isGreaterThan`=1, `ready` at E15. `start` pulses during RUN are ignored; a second `start` in the DONE cycle begins the next op at E16 with no IDLE cycle.
- Start A=B=0xFFFFFFFF, assert `reset` at E5 → IDLE, all outputs 0, no `ready`; a subsequent compare of 0xFFFFFFFF vs 0xFFFFFFFE → `isGreaterThan`=1 at E16.

Source files
------------

// File: rtl/comp_seq_ctrl.sv
`timescale 1ns/1ps
// comp_2 -- one 2-bit slice of the magnitude-compare cascade.
//   A, B   : 2-bit operand slice
//   EQ1    : all more-significant pairs were equal
//   GT1    : A was already greater on the more-significant pairs
//   EQ0    : equality carried through this slice
//   GT0    : greater-than carried through this slice
module comp_2 (
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       EQ1,
  input  logic       GT1,
  output logic       EQ0,
  output logic       GT0
);

  always_comb begin
    EQ0 = EQ1 & (A == B);
    GT0 = GT1 | (EQ1 & (A > B));
  end

endmodule

// comp_seq_ctrl -- sequential magnitude comparator.
// Walks one comp_2 slice across a WIDTH-bit operand pair, two bits per
// cycle from the MSB pair down, and stops as soon as a pair differs.
//   clock, reset  : single clock, synchronous active-high reset
//   start         : request a compare (taken in IDLE or DONE only)
//   is_signed     : two's-complement compare when 1, sampled with start
//   data_A/data_B : operands, sampled with start
//   busy          : high while the slice walk is in progress
//   ready         : one-cycle pulse when the result registers update
//   isEqual/isGreaterThan/isLessThan : registered one-hot result
// WIDTH must be even and at least 2.
module comp_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] data_A,
  input  logic [WIDTH-1:0] data_B,
  output logic             busy,
  output logic             ready,
  output logic             isEqual,
  output logic             isGreaterThan,
  output logic             isLessThan
);

  localparam int N  = WIDTH / 2;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [KW-1:0]    k;
  logic             eq_r;
  logic             gt_r;
  logic [1:0]       sa;
  logic [1:0]       sb;
  logic             eq0;
  logic             gt0;
  logic             accept;
  logic             finish;
  logic [WIDTH-1:0] sign_fix;

  // Flipping the sign bit of both operands maps two's-complement order
  // onto unsigned order, so the slice chain itself stays unsigned.
  always_comb begin
    sign_fix          = '0;
    sign_fix[WIDTH-1] = is_signed;
  end

  // Select the operand pair at index k.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (k == KW'(i)) begin
        sa = a_r[2*i +: 2];
        sb = b_r[2*i +: 2];
      end
    end
  end

  comp_2 u_slice (
    .A   (sa),
    .B   (sb),
    .EQ1 (eq_r),
    .GT1 (gt_r),
    .EQ0 (eq0),
    .GT0 (gt0)
  );

  // Next state, handshake strobes and status outputs.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    finish   = 1'b0;
    busy     = 1'b0;
    ready    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        // Once EQ0 drops the cascade can no longer change, so the
        // remaining lower pairs are skipped.
        if ((k == '0) || !eq0) begin
          finish   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        ready = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      a_r           <= '0;
      b_r           <= '0;
      k             <= '0;
      eq_r          <= 1'b0;
      gt_r          <= 1'b0;
      isEqual       <= 1'b0;
      isGreaterThan <= 1'b0;
      isLessThan    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r  <= data_A ^ sign_fix;
        b_r  <= data_B ^ sign_fix;
        eq_r <= 1'b1;
        gt_r <= 1'b0;
        k    <= KW'(N - 1);
      end else if (state == RUN) begin
        eq_r <= eq0;
        gt_r <= gt0;
        if (finish) begin
          isEqual       <= eq0;
          isGreaterThan <= gt0;
          isLessThan    <= ~eq0 & ~gt0;
        end else begin
          k <= k - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_comp_seq_ctrl.sv
`timescale 1ns/1ps
module tb_comp_seq_ctrl;

  localparam int W = 32;
  localparam int N = W / 2;

  logic         clock;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] data_A;
  logic [W-1:0] data_B;
  logic         busy;
  logic         ready;
  logic         isEqual;
  logic         isGreaterThan;
  logic         isLessThan;

  int tests = 0;
  int fails = 0;

  // last reported result, as the bench expects it to be held
  bit pe = 0, pg = 0, pl = 0;

  comp_seq_ctrl #(.WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .is_signed     (is_signed),
    .data_A        (data_A),
    .data_B        (data_B),
    .busy          (busy),
    .ready         (ready),
    .isEqual       (isEqual),
    .isGreaterThan (isGreaterThan),
    .isLessThan    (isLessThan)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Reference: ordering from plain integer compare, latency from the
  // position of the first differing 2-bit pair counted from the top.
  function automatic void ref_model(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output bit eq, output bit gt, output bit lt, output int lat);
    if (sgn) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    eq  = (a == b);
    lat = N;
    for (int p = 0; p < N; p++) begin
      int sh;
      sh = 2 * (N - 1 - p);
      if (((a >> sh) & 32'd3) != ((b >> sh) & 32'd3)) begin
        lat = p + 1;
        break;
      end
    end
  endfunction

  // Launch an op (inputs presented before the next edge) and follow it
  // to its ready pulse; optionally toggle start while running.
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit noise,
                        input bit ee, input bit eg, input bit el, input int elat, input string tag);
    int lat;
    int bc;
    start     = 1'b1;
    is_signed = sgn;
    data_A    = a;
    data_B    = b;
    @(posedge clock); #1;
    start     = 1'b0;
    is_signed = 1'($urandom);
    data_A    = $urandom;
    data_B    = $urandom;
    check({tag, " hold_in_run"}, {29'd0, isEqual, isGreaterThan, isLessThan}, {29'd0, pe, pg, pl});
    lat = 0;
    bc  = 0;
    while (!ready && lat < 40) begin
      if (busy) bc++;
      if (noise) start = 1'($urandom);
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    check({tag, " latency"}, lat, elat);
    check({tag, " busy_cycles"}, bc, elat);
    check({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
    check({tag, " result"}, {29'd0, isEqual, isGreaterThan, isLessThan}, {29'd0, ee, eg, el});
    pe = ee; pg = eg; pl = el;
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clock); #1;
    check({tag, " idle_status"}, {30'd0, busy, ready}, 32'd0);
    check({tag, " idle_hold"}, {29'd0, isEqual, isGreaterThan, isLessThan}, {29'd0, pe, pg, pl});
  endtask

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    bit          eq;
    bit          gt;
    bit          lt;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int rdy_seen;
    bit me, mg, ml;
    int mlat;

    vecs[0] = '{0, 32'h80000000, 32'h7FFFFFFF, 0, 1, 0, 1};
    vecs[1] = '{1, 32'h80000000, 32'h7FFFFFFF, 0, 0, 1, 1};
    vecs[2] = '{0, 32'h12345678, 32'h12345678, 1, 0, 0, 16};
    vecs[3] = '{0, 32'h00000001, 32'h00000002, 0, 0, 1, 16};
    vecs[4] = '{0, 32'h00000004, 32'h00000000, 0, 1, 0, 15};
    vecs[5] = '{1, 32'h80000000, 32'h00000001, 0, 0, 1, 1};
    vecs[6] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 1, 0, 16};
    vecs[7] = '{1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1, 0, 0, 16};
    vecs[8] = '{0, 32'h00000000, 32'hC0000000, 0, 0, 1, 1};
    vecs[9] = '{1, 32'h00000000, 32'hC0000000, 0, 1, 0, 1};

    // reset with start held high: nothing may launch
    reset     = 1'b1;
    start     = 1'b1;
    is_signed = 1'b0;
    data_A    = 32'h80000000;
    data_B    = 32'h1;
    repeat (2) @(posedge clock);
    #1;
    check("reset outputs", {27'd0, busy, ready, isEqual, isGreaterThan, isLessThan}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    idle_cycle("post_reset");

    foreach (vecs[i]) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b0,
             vecs[i].eq, vecs[i].gt, vecs[i].lt, vecs[i].lat, $sformatf("vec%0d", i));
      idle_cycle($sformatf("vec%0d", i));
    end

    // start pulses during RUN ignored, then back-to-back from DONE
    run_op(0, 32'h4, 32'h0, 1'b1, 0, 1, 0, 15, "noise");
    run_op(0, 32'h1, 32'h2, 1'b0, 0, 0, 1, 16, "b2b");
    idle_cycle("b2b");

    // reset in the middle of a run discards it
    start     = 1'b1;
    is_signed = 1'b0;
    data_A    = 32'hFFFFFFFF;
    data_B    = 32'hFFFFFFFF;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("midrun_reset outputs", {27'd0, busy, ready, isEqual, isGreaterThan, isLessThan}, 32'd0);
    reset = 1'b0;
    pe = 0; pg = 0; pl = 0;
    rdy_seen = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (ready || busy) rdy_seen++;
    end
    check("midrun_reset no_ready", rdy_seen, 0);
    run_op(0, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 0, 1, 0, 16, "after_reset");

    // randomized ops against the reference model
    for (int r = 0; r < 200; r++) begin
      bit          sgn;
      logic [31:0] a, b;
      int          m;
      sgn = 1'($urandom);
      a   = $urandom;
      m   = $urandom_range(0, 3);
      case (m)
        0: b = $urandom;
        1: b = a;
        2: b = a ^ (32'($urandom_range(1, 3)) << (2 * $urandom_range(0, N - 1)));
        default: b = a ^ 32'($urandom_range(0, 15));
      endcase
      ref_model(sgn, a, b, me, mg, ml, mlat);
      run_op(sgn, a, b, 1'($urandom), me, mg, ml, mlat, $sformatf("rnd%0d", r));
      if ($urandom_range(0, 1) == 0) idle_cycle($sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
